// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage owning the PC and the IF/ID pipeline register
// Ports: clk, rst (async, active-high); imem_addr (word address = pc[31:2]) / imem_data
//   (single-cycle combinational read); stall, flush, redirect_valid, redirect_pc control inputs;
//   pc, if_id_instr, if_id_pc_plus4, if_id_valid registered outputs.
// Optional FETCH_PERF_EN adds perf_fetch_cnt (valid captures) and perf_stall_cnt (pure stalls).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  logic [31:0] pc_plus4;
  logic        bubble;
  logic        capture;
  logic        unused_low;
  assign imem_addr  = pc[31:2];
  assign pc_plus4   = pc + 32'd4;
  // A redirect means the word fetched this cycle is wrong-path, so it is squashed like a flush.
  assign bubble     = flush | redirect_valid;
  assign capture    = !bubble && !stall;
  assign unused_low = ^redirect_pc[1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC;
    else pc <= redirect_valid ? {redirect_pc[31:2], 2'b00} : stall ? pc : pc_plus4;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
    end else if (bubble) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
    end else if (capture) begin
      if_id_instr    <= imem_data;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + {31'd0, capture};
      perf_stall_cnt <= perf_stall_cnt + {31'd0, stall & !bubble};
    end
`else
`endif
endmodule
